button_scan_ctrl: RTL and testbench
===================================

BUTTON_SCAN_CTRL -- requirements
Module: button_scan_ctrl

Interface
REQ-001 SHALL provide parameter NUM_BTN, default 4: number of button inputs scanned.
REQ-002 SHALL provide parameter TICK_DIV, default 60000: i_clk cycles per scan tick (5 ms at 12 MHz).
REQ-003 SHALL provide parameter STABLE_TICKS, default 4: consecutive differing samples required to flip a debounced level.
REQ-004 SHALL provide parameter REPEAT_DELAY, default 100: scan ticks of hold before the first auto-repeat pulse.
REQ-005 SHALL provide parameter REPEAT_RATE, default 20: scan ticks between subsequent auto-repeat pulses.
REQ-006 SHALL provide port i_clk, input, 1: single system clock; all logic on its rising edge.
REQ-007 SHALL provide port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL provide port i_buttons, input, NUM_BTN: raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL provide port o_level, output, NUM_BTN: debounced button levels.
REQ-010 SHALL provide port o_press, output, NUM_BTN: one-cycle pulse on debounced 0->1.
REQ-011 SHALL provide port o_release, output, NUM_BTN: one-cycle pulse on debounced 1->0.
REQ-012 SHALL provide port o_repeat, output, NUM_BTN: one-cycle auto-repeat pulse while held.

Function
REQ-013 SHALL pass each i_buttons bit through a two-flop synchronizer before any use.
REQ-014 SHALL run a tick counter 0..TICK_DIV-1, wrapping to 0; tick asserts for one cycle when counter equals TICK_DIV-1.
REQ-015 SHALL implement FSM states IDLE and SCAN; IDLE->SCAN on tick with index 0; SCAN increments index each cycle; SCAN->IDLE after index NUM_BTN-1.
REQ-016 SHALL use one shared update datapath: exactly one button (the current index) is evaluated per SCAN cycle.
REQ-017 SHALL evaluate button k in cycle T+1+k for tick in cycle T; its output pulses and o_level change appear registered in cycle T+2+k.
REQ-018 SHALL per button keep: level bit, stable counter (clog2(STABLE_TICKS)+1 bits), repeat counter (clog2(REPEAT_DELAY)+1 bits).
REQ-019 SHALL when sample equals level, clear the stable counter.
REQ-020 SHALL when sample differs from level, increment stable counter; on reaching STABLE_TICKS, invert level, clear counter, and pulse o_press (new level 1) or o_release (new level 0).
REQ-021 SHALL when level is 1 and no flip occurs, increment repeat counter; on reaching REPEAT_DELAY, pulse o_repeat and load REPEAT_DELAY-REPEAT_RATE.
REQ-022 SHALL clear repeat counter whenever level is 0 or flips; o_press and o_repeat never assert in the same cycle for one button.
REQ-023 SHALL keep all pulse outputs 0 in IDLE and for non-indexed buttons.
REQ-024 SHALL require TICK_DIV > NUM_BTN+1 (elaboration-time check), so a tick never arrives during SCAN.

Reset
REQ-025 SHALL on i_rst_n low asynchronously clear tick counter, synchronizers, all per-button state, index, and force FSM to IDLE.
REQ-026 SHALL drive o_level, o_press, o_release, o_repeat to all zeros during and after reset.
REQ-027 SHALL on reset mid-SCAN abandon the scan; no pulse is emitted for unscanned buttons; next scan starts at index 0 after first post-reset tick.

Structure
REQ-028 SHALL place FSM state enum and default parameter constants in shared package pong_input_pkg.
REQ-029 SHALL keep per-button state in arrays indexed by scan index; one sub-module, scan_tick_gen (tick counter), is natural.

Verification (TICK_DIV=8, STABLE_TICKS=4, REPEAT_DELAY=6, REPEAT_RATE=2, NUM_BTN=4)
REQ-030 SHALL test: button 2 held 1 steadily -> o_press[2] single pulse at 4th scan after synchronizer, o_level[2]=1, 2 cycles after that scan's tick +2.
REQ-031 SHALL test: button 0 toggled every scan tick for 10 ticks -> no o_press[0], o_level[0] stays 0.
REQ-032 SHALL test: button 1 held 20 ticks -> o_repeat[1] at 6 ticks after press, then every 2 ticks; release -> o_release[1] after 4 ticks, repeats stop.
REQ-033 SHALL test: all 4 buttons pressed same cycle -> o_press pulses in cycles T+2, T+3, T+4, T+5 of the 4th qualifying scan, one bit each.
REQ-034 SHALL test: i_rst_n low during SCAN index 1 -> all outputs 0 immediately, FSM IDLE, no pulses until new debounce completes.

Source files
------------

// File: rtl/pong_input_pkg.sv
// Shared definitions for the button input path.
// Holds the scan FSM state encoding and the default timing constants used
// by button_scan_ctrl and its tick generator.
package pong_input_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    localparam int DEF_NUM_BTN      = 4;
    localparam int DEF_TICK_DIV     = 60000;
    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_REPEAT_DELAY = 100;
    localparam int DEF_REPEAT_RATE  = 20;

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick generator.
// Counts i_clk cycles 0..TICK_DIV-1 and wraps to 0. o_tick is high for exactly
// the one cycle in which the count equals TICK_DIV-1. o_tick comes from a
// register: it is loaded from the next count, so it lines up with the
// counter without a combinational output path.
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   o_tick  - one-cycle scan tick
module scan_tick_gen
    import pong_input_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             tick_r;

    // next count with wrap at TICK_DIV-1
    always_comb begin
        cnt_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
    end

    // counter and tick registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            tick_r <= (cnt_s == CNT_LAST);
        end
    end

    assign o_tick = tick_r;

endmodule

// File: rtl/button_scan_ctrl.sv
// Time-multiplexed button debouncer with press/release/auto-repeat events.
// A scan tick starts a pass over all buttons; one button per cycle goes
// through a single shared update datapath (debounce counter, level, repeat
// counter). All outputs are registered.
// Ports:
//   i_clk     - system clock, rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_buttons - raw asynchronous button levels, 1 = pressed
//   o_level   - debounced levels
//   o_press   - one-cycle pulse on debounced 0->1
//   o_release - one-cycle pulse on debounced 1->0
//   o_repeat  - one-cycle auto-repeat pulse while held
module button_scan_ctrl
    import pong_input_pkg::*;
#(
    parameter int NUM_BTN      = DEF_NUM_BTN,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_buttons,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_repeat
);

    localparam int STB_W = $clog2(STABLE_TICKS) + 1;
    localparam int RPT_W = $clog2(REPEAT_DELAY) + 1;
    localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    localparam logic [STB_W-1:0]   STB_MAX    = STB_W'(STABLE_TICKS);
    localparam logic [STB_W-1:0]   STB_ONE    = STB_W'(1);
    localparam logic [RPT_W-1:0]   RPT_MAX    = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]   RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [RPT_W-1:0]   RPT_ONE    = RPT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_BTN - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [NUM_BTN-1:0] BTN_ONE    = NUM_BTN'(1);

    // The scan must finish before the next tick can arrive.
    if (TICK_DIV <= NUM_BTN + 1) begin : g_bad_tick_div
        $error("button_scan_ctrl: TICK_DIV must exceed NUM_BTN+1");
    end

    logic               tick_s;
    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    scan_state_e        state_r;
    scan_state_e        state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;

    logic [NUM_BTN-1:0] level_r;
    logic [STB_W-1:0]   stb_cnt_r [NUM_BTN];
    logic [RPT_W-1:0]   rpt_cnt_r [NUM_BTN];
    logic [NUM_BTN-1:0] press_r;
    logic [NUM_BTN-1:0] release_r;
    logic [NUM_BTN-1:0] repeat_r;

    logic               cur_sample_s;
    logic               cur_level_s;
    logic [STB_W-1:0]   cur_stb_s;
    logic [RPT_W-1:0]   cur_rpt_s;
    logic               nxt_level_s;
    logic [STB_W-1:0]   nxt_stb_s;
    logic [RPT_W-1:0]   nxt_rpt_s;
    logic               flip_s;
    logic               rpt_hit_s;
    logic [NUM_BTN-1:0] idx_onehot_s;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick_s)
    );

    // two-flop synchronizer on the raw button levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= i_buttons;
            sync2_r <= sync1_r;
        end
    end

    // scan FSM next state and index
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_s = ST_SCAN;
                    idx_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == IDX_LAST) begin
                    state_s = ST_IDLE;
                    idx_s   = '0;
                end else begin
                    idx_s = idx_r + IDX_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // scan FSM registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // shared update datapath for the currently indexed button
    always_comb begin
        cur_sample_s = sync2_r[idx_r];
        cur_level_s  = level_r[idx_r];
        cur_stb_s    = stb_cnt_r[idx_r];
        cur_rpt_s    = rpt_cnt_r[idx_r];
        idx_onehot_s = BTN_ONE << idx_r;
        nxt_level_s  = cur_level_s;
        nxt_stb_s    = cur_stb_s;
        nxt_rpt_s    = cur_rpt_s;
        flip_s       = 1'b0;
        rpt_hit_s    = 1'b0;

        if (cur_sample_s == cur_level_s) begin
            nxt_stb_s = '0;
        end else if ((cur_stb_s + STB_ONE) == STB_MAX) begin
            flip_s      = 1'b1;
            nxt_level_s = ~cur_level_s;
            nxt_stb_s   = '0;
        end else begin
            nxt_stb_s = cur_stb_s + STB_ONE;
        end

        // repeat only runs on a held level that is not flipping this scan
        if (flip_s || !cur_level_s) begin
            nxt_rpt_s = '0;
        end else if ((cur_rpt_s + RPT_ONE) == RPT_MAX) begin
            rpt_hit_s = 1'b1;
            nxt_rpt_s = RPT_RELOAD;
        end else begin
            nxt_rpt_s = cur_rpt_s + RPT_ONE;
        end
    end

    // per-button state write-back and registered event pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
            repeat_r  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                stb_cnt_r[i] <= '0;
                rpt_cnt_r[i] <= '0;
            end
        end else if (state_r == ST_SCAN) begin
            level_r[idx_r]   <= nxt_level_s;
            stb_cnt_r[idx_r] <= nxt_stb_s;
            rpt_cnt_r[idx_r] <= nxt_rpt_s;
            press_r   <= (flip_s && nxt_level_s)  ? idx_onehot_s : '0;
            release_r <= (flip_s && !nxt_level_s) ? idx_onehot_s : '0;
            repeat_r  <= rpt_hit_s                ? idx_onehot_s : '0;
        end else begin
            press_r   <= '0;
            release_r <= '0;
            repeat_r  <= '0;
        end
    end

    assign o_level   = level_r;
    assign o_press   = press_r;
    assign o_release = release_r;
    assign o_repeat  = repeat_r;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed self-checking bench for button_scan_ctrl with
// TICK_DIV=8, STABLE_TICKS=4, REPEAT_DELAY=6, REPEAT_RATE=2, NUM_BTN=4.
// Time base: edge_cnt counts rising edges after reset release (released on a
// falling edge). Ticks are visible after edges 8m+7; button k of scan m is
// evaluated after edge 8m+8+k and its result is visible after edge 8m+9+k.
// An input driven just after edge e reaches the datapath after edge e+2.
module tb_button_scan_ctrl;
    import pong_input_pkg::*;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_buttons;
    logic [3:0] o_level;
    logic [3:0] o_press;
    logic [3:0] o_release;
    logic [3:0] o_repeat;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int edge_cnt = 0;

    button_scan_ctrl #(
        .NUM_BTN      (4),
        .TICK_DIV     (8),
        .STABLE_TICKS (4),
        .REPEAT_DELAY (6),
        .REPEAT_RATE  (2)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_buttons (i_buttons),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // advance to just after rising edge e (counted from reset release)
    task automatic to_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge i_clk);
            edge_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        i_rst_n   = 1'b0;
        i_buttons = 4'b0000;
        @(posedge i_clk);
        #1;
        chk_cnt++;
        if ({o_level, o_press, o_release, o_repeat} !== 16'h0000)
            $display("FAIL reset_hold actual=%h required=0000", {o_level, o_press, o_release, o_repeat});
        else pass_cnt++;
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (dut.state_r !== ST_IDLE) $display("FAIL reset_state actual=%0d required=%0d", dut.state_r, ST_IDLE);
        else pass_cnt++;
        for (int e = 1; e <= 8; e++) begin
            to_edge(e);
            chk_cnt++;
            if ({o_level, o_press, o_release, o_repeat} !== 16'h0000)
                $display("FAIL reset_idle e=%0d actual=%h required=0000", e, {o_level, o_press, o_release, o_repeat});
            else pass_cnt++;
        end
    endtask

    task automatic test_press();
        do_reset();
        i_buttons = 4'b0100;
        to_edge(34);
        chk_cnt++;
        if (o_press !== 4'b0000 || o_level !== 4'b0000)
            $display("FAIL press_early press=%b level=%b required=0000/0000", o_press, o_level);
        else pass_cnt++;
        to_edge(35);
        chk_cnt++;
        if (o_press !== 4'b0100 || o_level !== 4'b0100 || o_release !== 4'b0000 || o_repeat !== 4'b0000)
            $display("FAIL press_pulse press=%b level=%b rel=%b rpt=%b required=0100/0100/0000/0000",
                     o_press, o_level, o_release, o_repeat);
        else pass_cnt++;
        to_edge(36);
        chk_cnt++;
        if (o_press !== 4'b0000 || o_level !== 4'b0100)
            $display("FAIL press_after press=%b level=%b required=0000/0100", o_press, o_level);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int m = 0; m < 10; m++) begin
            to_edge(8 * m + 2);
            i_buttons = (m % 2 == 0) ? 4'b0001 : 4'b0000;
            to_edge(8 * m + 9);
            chk_cnt++;
            if (o_press !== 4'b0000 || o_level !== 4'b0000)
                $display("FAIL bounce m=%0d press=%b level=%b required=0000/0000", m, o_press, o_level);
            else pass_cnt++;
        end
        i_buttons = 4'b0000;
    endtask

    task automatic test_repeat();
        logic [3:0] exp_press, exp_rel, exp_rpt, exp_lvl;
        do_reset();
        i_buttons = 4'b0010;
        for (int m = 0; m < 28; m++) begin
            to_edge(8 * m + 10);
            exp_press = (m == 3)  ? 4'b0010 : 4'b0000;
            exp_rel   = (m == 23) ? 4'b0010 : 4'b0000;
            exp_rpt   = (m >= 9 && m <= 21 && (m % 2 == 1)) ? 4'b0010 : 4'b0000;
            exp_lvl   = (m >= 3 && m < 23) ? 4'b0010 : 4'b0000;
            chk_cnt++;
            if (o_press !== exp_press || o_release !== exp_rel || o_repeat !== exp_rpt || o_level !== exp_lvl)
                $display("FAIL repeat m=%0d press=%b rel=%b rpt=%b lvl=%b required=%b/%b/%b/%b",
                         m, o_press, o_release, o_repeat, o_level, exp_press, exp_rel, exp_rpt, exp_lvl);
            else pass_cnt++;
            if (m == 19) i_buttons = 4'b0000;
            to_edge(8 * m + 11);
            chk_cnt++;
            if ({o_press, o_release, o_repeat} !== 12'h000)
                $display("FAIL repeat_width m=%0d actual=%h required=000", m, {o_press, o_release, o_repeat});
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_press, exp_lvl;
        do_reset();
        i_buttons = 4'b1111;
        for (int e = 32; e <= 37; e++) begin
            to_edge(e);
            exp_press = 4'b0000;
            exp_lvl   = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                if (e == 33 + k) exp_press[k] = 1'b1;
                if (e >= 33 + k) exp_lvl[k] = 1'b1;
            end
            chk_cnt++;
            if (o_press !== exp_press || o_level !== exp_lvl)
                $display("FAIL all_press e=%0d press=%b level=%b required=%b/%b", e, o_press, o_level, exp_press, exp_lvl);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        i_buttons = 4'b1111;
        to_edge(33);
        chk_cnt++;
        if (o_press !== 4'b0001) $display("FAIL midscan_pre press=%b required=0001", o_press);
        else pass_cnt++;
        i_rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({o_level, o_press, o_release, o_repeat} !== 16'h0000)
            $display("FAIL midscan_async actual=%h required=0000", {o_level, o_press, o_release, o_repeat});
        else pass_cnt++;
        chk_cnt++;
        if (dut.state_r !== ST_IDLE || dut.idx_r !== 2'd0)
            $display("FAIL midscan_fsm state=%0d idx=%0d required=0/0", dut.state_r, dut.idx_r);
        else pass_cnt++;
        repeat (2) @(negedge i_clk);
        i_rst_n  = 1'b1;
        edge_cnt = 0;
        for (int e = 1; e <= 32; e++) begin
            to_edge(e);
            chk_cnt++;
            if ({o_level, o_press, o_release, o_repeat} !== 16'h0000)
                $display("FAIL midscan_quiet e=%0d actual=%h required=0000", e, {o_level, o_press, o_release, o_repeat});
            else pass_cnt++;
        end
        to_edge(33);
        chk_cnt++;
        if (o_press !== 4'b0001 || o_level !== 4'b0001)
            $display("FAIL midscan_redo press=%b level=%b required=0001/0001", o_press, o_level);
        else pass_cnt++;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_buttons = 4'b0000;
        test_reset();
        test_press();
        test_bounce();
        test_repeat();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
